// File: rtl/load_unit_seq_pkg.sv
// Shared definitions for the sequential load unit.
// Contents: funct3 encodings, FSM state type, load_size() byte count and
// is_legal() funct3 legality check for a given XLEN.
package lsu_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ0  = 3'd1,
      ST_WAIT0 = 3'd2,
      ST_REQ1  = 3'd3,
      ST_WAIT1 = 3'd4,
      ST_RESP  = 3'd5
   } load_state_e;

   // Byte count of the access; only meaningful for legal encodings.
   function automatic logic [3:0] load_size(input logic [2:0] funct3);
      case (funct3)
         F3_LB, F3_LBU: load_size = 4'd1;
         F3_LH, F3_LHU: load_size = 4'd2;
         F3_LW, F3_LWU: load_size = 4'd4;
         default:       load_size = 4'd8;
      endcase
   endfunction

   function automatic logic is_legal(input logic [2:0] funct3, input int xlen);
      case (funct3)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal = 1'b1;
         F3_LD, F3_LWU:                       is_legal = (xlen == 64);
         default:                             is_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_unit_seq_if.sv
// Handshake bundle of the load unit: request port (from LSU), memory read
// port (to bus) and response port (to writeback).
// Modports: slave = load unit side, master = environment side.
interface load_unit_seq_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
);
   logic              req_valid;
   logic              req_ready;
   logic [2:0]        req_funct3;
   logic [ADDR_W-1:0] req_addr;
   logic [TAG_W-1:0]  req_tag;

   logic              mem_req_valid;
   logic              mem_req_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rsp_valid;
   logic [XLEN-1:0]   mem_rdata;

   logic              rsp_valid;
   logic              rsp_ready;
   logic [XLEN-1:0]   rsp_data;
   logic [TAG_W-1:0]  rsp_tag;
   logic              rsp_err;

   modport slave (
      input  req_valid, req_funct3, req_addr, req_tag,
      output req_ready,
      output mem_req_valid, mem_addr,
      input  mem_req_ready, mem_rsp_valid, mem_rdata,
      output rsp_valid, rsp_data, rsp_tag, rsp_err,
      input  rsp_ready
   );

   modport master (
      output req_valid, req_funct3, req_addr, req_tag,
      input  req_ready,
      input  mem_req_valid, mem_addr,
      output mem_req_ready, mem_rsp_valid, mem_rdata,
      input  rsp_valid, rsp_data, rsp_tag, rsp_err,
      output rsp_ready
   );
endinterface

// File: rtl/load_unit_seq_extract.sv
// load_extract: combinational byte/half/word/double extraction.
// Ports:
//   i_funct3  load encoding (selects size and sign/zero extension)
//   i_off     byte offset of the access within the low bus word
//   i_lo      low bus word, i_hi following bus word (little-endian)
//   o_data    extended XLEN result
module load_extract
   import lsu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int OFF_W = $clog2(XLEN/8)
) (
   input  logic [2:0]       i_funct3,
   input  logic [OFF_W-1:0] i_off,
   input  logic [XLEN-1:0]  i_lo,
   input  logic [XLEN-1:0]  i_hi,
   output logic [XLEN-1:0]  o_data
);
   logic [2*XLEN-1:0] w_cat;
   logic [XLEN-1:0]   w_shift;

   assign w_cat   = {i_hi, i_lo};
   // Bring the addressed byte down to bit 0; bytes past the access are ignored.
   assign w_shift = XLEN'(w_cat >> {i_off, 3'b000});

   always_comb begin
      o_data = '0;
      case (i_funct3)
         F3_LB:   o_data = XLEN'($signed(w_shift[7:0]));
         F3_LH:   o_data = XLEN'($signed(w_shift[15:0]));
         F3_LW:   o_data = XLEN'($signed(w_shift[31:0]));
         F3_LBU:  o_data = XLEN'(w_shift[7:0]);
         F3_LHU:  o_data = XLEN'(w_shift[15:0]);
         F3_LWU:  o_data = XLEN'(w_shift[31:0]);
         F3_LD:   o_data = w_shift;
         default: o_data = '0;
      endcase
   end
endmodule

// File: rtl/load_unit_seq.sv
// load_unit_seq: sequential load unit. Accepts one load at a time, reads the
// aligned bus word(s), extracts/extends the result and returns it with its tag.
// Ports:
//   clk    clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    load_unit_seq_if.slave (request, memory read, response handshakes)
// Optional feature macro: LSU_MISALIGN_SPLIT_EN
//   defined   -> accesses crossing a bus word are split into two reads
//   undefined -> crossing accesses are answered with rsp_err=1, no memory read
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for a request, req_ready=1
// ST_REQ0  | presenting read of the aligned (low) word
// ST_WAIT0 | waiting for low word data
// ST_REQ1  | presenting read of the following word (split build only)
// ST_WAIT1 | waiting for high word data (split build only)
// ST_RESP  | holding result until rsp_ready
module load_unit_seq
   import lsu_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 5
) (
   input logic               clk,
   input logic               rst_n,
   load_unit_seq_if.slave    bus
);
   localparam int BYTES = XLEN / 8;
   localparam int OFF_W = $clog2(BYTES);

   load_state_e       r_state;
   logic [2:0]        r_funct3;
   logic [OFF_W-1:0]  r_off;
   logic              r_mem_req_valid;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_rsp_valid;
   logic [XLEN-1:0]   r_rsp_data;
   logic [TAG_W-1:0]  r_rsp_tag;
   logic              r_rsp_err;
`ifdef LSU_MISALIGN_SPLIT_EN
   logic              r_cross;
   logic [ADDR_W-1:0] r_addr_al;
   logic [XLEN-1:0]   r_lo;
`endif

   logic [OFF_W-1:0]  w_req_off;
   logic [ADDR_W-1:0] w_req_aligned;
   logic [4:0]        w_req_end;
   logic              w_req_cross;
   logic              w_req_legal;
   logic [XLEN-1:0]   w_ext_lo;
   logic [XLEN-1:0]   w_ext_hi;
   logic [XLEN-1:0]   w_ext_data;

   assign w_req_off     = bus.req_addr[OFF_W-1:0];
   assign w_req_aligned = {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
   assign w_req_end     = 5'(w_req_off) + 5'(load_size(bus.req_funct3));
   assign w_req_cross   = (w_req_end > 5'(BYTES));
   assign w_req_legal   = is_legal(bus.req_funct3, XLEN);

`ifdef LSU_MISALIGN_SPLIT_EN
   // In WAIT1 the low word is already captured and the bus carries the high one.
   assign w_ext_lo = (r_state == ST_WAIT1) ? r_lo : bus.mem_rdata;
   assign w_ext_hi = bus.mem_rdata;
`else
   assign w_ext_lo = bus.mem_rdata;
   assign w_ext_hi = '0;
`endif

   load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extract (
      .i_funct3 (r_funct3),
      .i_off    (r_off),
      .i_lo     (w_ext_lo),
      .i_hi     (w_ext_hi),
      .o_data   (w_ext_data)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_funct3        <= '0;
         r_off           <= '0;
         r_mem_req_valid <= 1'b0;
         r_mem_addr      <= '0;
         r_rsp_valid     <= 1'b0;
         r_rsp_data      <= '0;
         r_rsp_tag       <= '0;
         r_rsp_err       <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
         r_cross         <= 1'b0;
         r_addr_al       <= '0;
         r_lo            <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  r_funct3  <= bus.req_funct3;
                  r_off     <= w_req_off;
                  r_rsp_tag <= bus.req_tag;
`ifdef LSU_MISALIGN_SPLIT_EN
                  r_cross   <= w_req_cross;
                  r_addr_al <= w_req_aligned;
                  if (!w_req_legal) begin
`else
                  if (!w_req_legal || w_req_cross) begin
`endif
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_data  <= '0;
                     r_state     <= ST_RESP;
                  end else begin
                     r_mem_req_valid <= 1'b1;
                     r_mem_addr      <= w_req_aligned;
                     r_state         <= ST_REQ0;
                  end
               end
            end
            ST_REQ0: begin
               if (bus.mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= ST_WAIT0;
               end
            end
            ST_WAIT0: begin
               if (bus.mem_rsp_valid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                  r_lo <= bus.mem_rdata;
                  if (r_cross) begin
                     r_mem_req_valid <= 1'b1;
                     // Wraps naturally at the top of the address space.
                     r_mem_addr      <= r_addr_al + ADDR_W'(BYTES);
                     r_state         <= ST_REQ1;
                  end else begin
`else
                  begin
`endif
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b0;
                     r_rsp_data  <= w_ext_data;
                     r_state     <= ST_RESP;
                  end
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_REQ1: begin
               if (bus.mem_req_ready) begin
                  r_mem_req_valid <= 1'b0;
                  r_state         <= ST_WAIT1;
               end
            end
            ST_WAIT1: begin
               if (bus.mem_rsp_valid) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_data  <= w_ext_data;
                  r_state     <= ST_RESP;
               end
            end
`endif
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_mem_req_valid <= 1'b0;
               r_rsp_valid     <= 1'b0;
               r_state         <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready     = (r_state == ST_IDLE);
   assign bus.mem_req_valid = r_mem_req_valid;
   assign bus.mem_addr      = r_mem_addr;
   assign bus.rsp_valid     = r_rsp_valid;
   assign bus.rsp_data      = r_rsp_data;
   assign bus.rsp_tag       = r_rsp_tag;
   assign bus.rsp_err       = r_rsp_err;

endmodule

// File: tb/tb_load_unit_seq.sv
module tb_load_unit_seq;
`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic [4:0]  tag;
      logic        err;
   } exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   bit   auto_mem;
   bit   fast_mem;
   bit   hold_rsp;

   exp_t        exp_q[$];
   logic [31:0] addr_q[$];
   logic [31:0] mem[logic [31:0]];

   load_unit_seq_if #(.XLEN(32), .ADDR_W(32), .TAG_W(5)) bus ();

   load_unit_seq #(.XLEN(32), .ADDR_W(32), .TAG_W(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] get_word(input logic [31:0] wa);
      if (!mem.exists(wa)) mem[wa] = $urandom;
      return mem[wa];
   endfunction

   // Reference: gather `size` bytes from a byte-addressed view of memory.
   task automatic model(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] tag);
      exp_t        e;
      int          size;
      int          off;
      bit          legal;
      logic [31:0] al;
      logic [63:0] v;
      legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
      case (f3[1:0])
         2'd0: size = 1;
         2'd1: size = 2;
         2'd2: size = 4;
         default: size = 8;
      endcase
      off    = int'(a % 4);
      al     = a - (a % 4);
      e.tag  = tag;
      e.err  = 1'b0;
      e.data = 32'h0;
      if (!legal || (off + size > 4 && !SPLIT)) begin
         e.err = 1'b1;
      end else begin
         addr_q.push_back(al);
         if (off + size > 4) addr_q.push_back(al + 32'd4);
         v = 64'h0;
         for (int i = 0; i < size; i++) begin
            int          p;
            logic [31:0] w;
            p = off + i;
            w = get_word((p >= 4) ? al + 32'd4 : al);
            v = v | (64'((w >> (8 * (p % 4))) & 32'hFF) << (8 * i));
         end
         if (!f3[2] && v[8*size-1]) v = v | ~((64'd1 << (8 * size)) - 64'd1);
         e.data = v[31:0];
      end
      exp_q.push_back(e);
   endtask

   task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] tag);
      int n;
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_funct3 = f3;
      bus.req_addr   = a;
      bus.req_tag    = tag;
      n = 0;
      while (!bus.req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) chk("req_accept_timeout", 64'(n), 64'(0));
      @(posedge clk);
      #1 bus.req_valid = 1'b0;
   endtask

   task automatic send_req(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] tag);
      model(f3, a, tag);
      drive_req(f3, a, tag);
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || !bus.req_ready) && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("txn_timeout", 64'(n), 64'(0));
      chk("mem_reads_outstanding", 64'(addr_q.size()), 64'(0));
   endtask

   // Memory responder: checks every read address against the model's list.
   initial begin
      logic [31:0] a;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rdata     = 32'h0;
      forever begin
         @(negedge clk);
         if (auto_mem && rst_n) begin
            bus.mem_req_ready = fast_mem ? 1'b1 : 1'($urandom_range(0, 1));
            if (bus.mem_req_valid && bus.mem_req_ready) begin
               a = bus.mem_addr;
               if (addr_q.size() == 0) begin
                  chk("mem_unexpected_read", 64'(a), 64'hFFFF_FFFF_FFFF_FFFF);
               end else begin
                  chk("mem_addr", 64'(a), 64'(addr_q.pop_front()));
               end
               @(posedge clk);
               @(negedge clk);
               bus.mem_req_ready = 1'b0;
               if (!fast_mem) repeat ($urandom_range(0, 2)) @(negedge clk);
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rdata     = get_word(a);
               @(negedge clk);
               bus.mem_rsp_valid = 1'b0;
               bus.mem_rdata     = $urandom;
            end
         end
      end
   end

   initial begin
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 bus.rsp_ready = hold_rsp ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
   end

   // Scoreboard monitor: a handshake happens at the next posedge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("rsp_unexpected", 64'(bus.rsp_data), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_data", 64'(bus.rsp_data), 64'(e.data));
               chk("rsp_tag",  64'(bus.rsp_tag),  64'(e.tag));
               chk("rsp_err",  64'(bus.rsp_err),  64'(e.err));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      checks         = 0;
      errors         = 0;
      auto_mem       = 1'b0;
      fast_mem       = 1'b0;
      hold_rsp       = 1'b0;
      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_funct3 = 3'd0;
      bus.req_addr   = 32'h0;
      bus.req_tag    = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready",     64'(bus.req_ready),     64'(1));
      chk("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
      chk("rst_rsp_valid",     64'(bus.rsp_valid),     64'(0));
      chk("rst_rsp_err",       64'(bus.rsp_err),       64'(0));
      chk("rst_mem_addr",      64'(bus.mem_addr),      64'(0));
      chk("rst_rsp_data",      64'(bus.rsp_data),      64'(0));
      chk("rst_rsp_tag",       64'(bus.rsp_tag),       64'(0));
      rst_n    = 1'b1;
      auto_mem = 1'b1;

      // Aligned LW with zero-wait memory: latency check.
      fast_mem = 1'b1;
      mem[32'h1000] = 32'hABCDEF12;
      send_req(3'b010, 32'h1000, 5'd1);
      @(negedge clk);
      chk("lat_mem_req_cycle1", 64'(bus.mem_req_valid), 64'(1));
      k = 1;
      while (!bus.rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("lat_rsp_valid_cycle", 64'(k), 64'(3));
      wait_done();
      fast_mem = 1'b0;

      mem[32'h1000] = 32'h8234ABCD;
      send_req(3'b001, 32'h1002, 5'd2);  wait_done();
      send_req(3'b101, 32'h1002, 5'd3);  wait_done();
      mem[32'h1000] = 32'h80FFFFFF;
      mem[32'h1004] = 32'h0000007F;
      send_req(3'b000, 32'h1003, 5'd4);  wait_done();
      send_req(3'b100, 32'h1004, 5'd5);  wait_done();
      mem[32'h1000] = 32'h44332211;
      mem[32'h1004] = 32'h88776655;
      send_req(3'b010, 32'h1003, 5'd6);  wait_done();
      send_req(3'b001, 32'h1001, 5'd7);  wait_done();
      send_req(3'b001, 32'h1003, 5'd8);  wait_done();

      // Illegal funct3 with response back-pressure.
      hold_rsp = 1'b1;
      @(posedge clk);
      #2;
      send_req(3'b011, 32'h1000, 5'd9);
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      repeat (4) begin
         @(negedge clk);
         chk("hold_rsp_valid", 64'(bus.rsp_valid), 64'(1));
         chk("hold_rsp_data",  64'(bus.rsp_data),  64'(0));
         chk("hold_rsp_tag",   64'(bus.rsp_tag),   64'(9));
         chk("hold_rsp_err",   64'(bus.rsp_err),   64'(1));
         chk("hold_req_ready", 64'(bus.req_ready), 64'(0));
      end
      hold_rsp = 1'b0;
      wait_done();

      // Reset while in WAIT0, then a stale memory response.
      auto_mem = 1'b0;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      drive_req(3'b010, 32'h3000, 5'd10);
      k = 0;
      while (!bus.mem_req_valid && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("rst_test_mem_req", 64'(bus.mem_req_valid), 64'(1));
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rdata     = 32'hDEADBEEF;
      repeat (2) begin
         @(negedge clk);
         chk("post_rst_rsp_valid",     64'(bus.rsp_valid),     64'(0));
         chk("post_rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
         chk("post_rst_req_ready",     64'(bus.req_ready),     64'(1));
      end
      bus.mem_rsp_valid = 1'b0;
      auto_mem = 1'b1;
      mem[32'h2000] = 32'h13572468;
      send_req(3'b010, 32'h2000, 5'd11);
      wait_done();

      // Randomized traffic, including accesses near the top of memory.
      for (int t = 0; t < 200; t++) begin
         logic [31:0] a;
         if ($urandom_range(0, 9) == 0) a = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
         else                           a = 32'h0000_1000 + 32'($urandom_range(0, 255));
         send_req(3'($urandom_range(0, 7)), a, 5'($urandom_range(0, 31)));
         wait_done();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
